aes128_round_sequencer: RTL and testbench

- Control block for the AES-128 encryption engine: owns the 128-bit cipher state register and runs the 11 AddRoundKey steps and 10 rounds.
- Issues each round's state to the external round datapath (SubBytes -> ShiftRows -> mixcolumn). Skips mixcolumn on round 10 by asserting a bypass.
- Selects the round-key index for the key schedule store and XORs the returned round key into the datapath result.
- Sits between the top-level start/plaintext interface and the round datapath plus key schedule.

---
 rtl/aes128_round_sequencer.sv | 127 ++++++++++++
 tb/tb_aes128_round_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sequencer.sv
// AES-128 round sequencer.
// Holds the 128-bit cipher state, applies the initial AddRoundKey, and runs
// the ten rounds through an external SubBytes/ShiftRows/MixColumns datapath.
// It supplies round-key indices to the key store and folds each returned key
// into the datapath result. The final round has its MixColumns step bypassed.
module aes128_round_sequencer #(
  parameter int DP_LAT     = 1,   // datapath latency in cycles, 1..8
  parameter int NUM_ROUNDS = 10   // fixed for AES-128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         ready,
  output logic [127:0] dp_state,
  output logic         dp_issue,
  output logic         dp_bypass_mix,
  input  logic [127:0] dp_result,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic [127:0] ciphertext,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAT        = 4'(DP_LAT);

  fsm_e         fsm_q,   fsm_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   wait_q,  wait_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q,    ct_d;

  // State register update with synchronous reset that discards any in-flight block.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the order of these statements carries no meaning.
    if (rst) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      wait_q  <= '0;
      state_q <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      state_q <= state_d;
      ct_q    <= ct_d;
    end
  end

  // Next-state logic and per-state outputs for the round sequence.
  always_comb begin
    // NOTE: every signal written here receives a default first; a branch that
    // forgot one would otherwise infer a latch.
    fsm_d         = fsm_q;
    round_d       = round_q;
    wait_d        = wait_q;
    state_d       = state_q;
    ct_d          = ct_q;
    ready         = 1'b0;
    dp_issue      = 1'b0;
    dp_bypass_mix = 1'b0;
    done          = 1'b0;
    rk_idx        = round_q;

    unique case (fsm_q)
      S_IDLE: begin
        ready   = 1'b1;
        rk_idx  = 4'd0;
        round_d = 4'd0;
        wait_d  = 4'd0;
        if (start) begin
          // Initial AddRoundKey with key 0 happens on the accepting edge.
          state_d = plaintext ^ round_key;
          round_d = 4'd1;
          fsm_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        dp_issue      = 1'b1;
        dp_bypass_mix = (round_q == LAST_ROUND);
        wait_d        = LAT;
        fsm_d         = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end
        // The result is valid in the last wait cycle; fold in this round's key.
        if (wait_q <= 4'd1) begin
          state_d = dp_result ^ round_key;
          if (round_q == LAST_ROUND) begin
            ct_d  = dp_result ^ round_key;
            fsm_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            fsm_d   = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        done  = 1'b1;
        fsm_d = S_IDLE;
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  assign dp_state   = state_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Testbench for aes128_round_sequencer.
// Instance A uses a behavioural AES round datapath (DP_LAT=1) and key schedule.
// Instance B uses a pass-through stub datapath (DP_LAT=3) with key = rk_idx.
module tb_aes128_round_sequencer;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A signals
  logic         start_a;
  logic [127:0] pt_a;
  logic         ready_a;
  logic [127:0] dp_state_a;
  logic         dp_issue_a;
  logic         dp_bypass_a;
  logic [127:0] dp_result_a = '0;
  logic [3:0]   rk_idx_a;
  logic [127:0] round_key_a;
  logic [127:0] ct_a;
  logic         done_a;

  // Instance B signals
  logic         start_b;
  logic [127:0] pt_b;
  logic         ready_b;
  logic [127:0] dp_state_b;
  logic         dp_issue_b;
  logic         dp_bypass_b;
  logic [127:0] dp_result_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] round_key_b;
  logic [127:0] ct_b;
  logic         done_b;

  aes128_round_sequencer #(.DP_LAT(1), .NUM_ROUNDS(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .plaintext(pt_a), .ready(ready_a),
    .dp_state(dp_state_a), .dp_issue(dp_issue_a), .dp_bypass_mix(dp_bypass_a),
    .dp_result(dp_result_a), .rk_idx(rk_idx_a), .round_key(round_key_a),
    .ciphertext(ct_a), .done(done_a)
  );

  aes128_round_sequencer #(.DP_LAT(3), .NUM_ROUNDS(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .plaintext(pt_b), .ready(ready_b),
    .dp_state(dp_state_b), .dp_issue(dp_issue_b), .dp_bypass_mix(dp_bypass_b),
    .dp_result(dp_result_b), .rk_idx(rk_idx_b), .round_key(round_key_b),
    .ciphertext(ct_b), .done(done_b)
  );

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tab [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] a8;
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      a8  = 8'(i);
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, a8);
      end
      sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // One AES round without AddRoundKey: SubBytes, ShiftRows, optional MixColumns.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic skip_mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[c*4+rr] = a[((c + rr) % 4)*4 + rr];
    if (!skip_mix) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[c*4]; c1 = b[c*4+1]; c2 = b[c*4+2]; c3 = b[c*4+3];
        b[c*4]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
        b[c*4+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
        b[c*4+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
        b[c*4+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  // Key expansion into rk_tab[0..10].
  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
            ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk_tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    for (int k = 11; k < 16; k++) rk_tab[k] = '0;
  endtask

  // Full AES-128 encryption of one block with the loaded schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rk_tab[r];
    return s;
  endfunction

  // Stub reference: the pass-through datapath leaves only the XOR of keys 0..10.
  function automatic logic [127:0] stub_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int k = 0; k <= 10; k++) s = s ^ 128'(k);
    return s;
  endfunction

  // ---------------- external blocks ----------------
  assign round_key_a = rk_tab[rk_idx_a];
  always @(posedge clk) begin
    if (dp_issue_a) dp_result_a <= aes_round(dp_state_a, dp_bypass_a);
  end

  assign dp_result_b = dp_state_b;
  assign round_key_b = {124'h0, rk_idx_b};

  // ---------------- monitors ----------------
  int           edge_n = 0;
  int           acc_edge_a = 0, done_edge_a = 0, done_cnt_a = 0, issue_cnt_a = 0;
  logic [127:0] issue_log_a [16];
  logic [127:0] done_ct_a = '0;
  int           acc_edge_b = 0, done_edge_b = 0, done_cnt_b = 0, issue_cnt_b = 0;
  int           bypass_cnt_b = 0, bypass_at_b = 0, bypass_stray_b = 0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst && start_a && ready_a) begin
      acc_edge_a  <= edge_n;
      issue_cnt_a <= 0;
    end
    if (dp_issue_a) begin
      issue_log_a[issue_cnt_a[3:0]] <= dp_state_a;
      issue_cnt_a <= issue_cnt_a + 1;
    end
    if (done_a) begin
      done_cnt_a  <= done_cnt_a + 1;
      done_edge_a <= edge_n;
      done_ct_a   <= ct_a;
    end
    if (!rst && start_b && ready_b) begin
      acc_edge_b   <= edge_n;
      issue_cnt_b  <= 0;
      bypass_cnt_b <= 0;
    end
    if (dp_issue_b) issue_cnt_b <= issue_cnt_b + 1;
    if (dp_bypass_b && dp_issue_b) begin
      bypass_cnt_b <= bypass_cnt_b + 1;
      bypass_at_b  <= issue_cnt_b + 1;
    end
    if (dp_bypass_b && !dp_issue_b) bypass_stray_b <= bypass_stray_b + 1;
    if (done_b) begin
      done_cnt_b  <= done_cnt_b + 1;
      done_edge_b <= edge_n;
    end
  end

  // ---------------- checking ----------------
  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until instance A has produced more than 'target-1' done pulses.
  task automatic wait_done_a(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(done_cnt_a >= target), 128'd1);
  endtask

  // Start one block on instance A from IDLE and wait for its done pulse.
  task automatic run_a(input logic [127:0] pt);
    int d0;
    d0 = done_cnt_a;
    @(negedge clk);
    pt_a    = pt;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(d0 + 1, 100, "a_done_timeout");
  endtask

  initial begin
    int d0, d1_edge, n;
    logic [127:0] pt, key;
    rst = 1'b1;
    start_a = 1'b0; pt_a = '0;
    start_b = 1'b0; pt_b = '0;
    build_sbox();
    load_key(FIPS_KEY);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",   128'(ready_a),     128'd1);
    check("rst_done",    128'(done_a),      128'd0);
    check("rst_ct",      ct_a,              128'd0);
    check("rst_rk_idx",  128'(rk_idx_a),    128'd0);
    check("rst_issue",   128'(dp_issue_a),  128'd0);
    check("rst_bypass",  128'(dp_bypass_a), 128'd0);
    check("rst_state",   dp_state_a,        128'd0);
    check("model_fips",  aes_ref(FIPS_PT),  FIPS_CT);

    // FIPS-197 Appendix B block
    run_a(FIPS_PT);
    check("fips_ct",       ct_a,      FIPS_CT);
    check("fips_ct_done",  done_ct_a, FIPS_CT);
    check("fips_latency",  128'(done_edge_a - 1 - acc_edge_a), 128'd20);
    check("fips_issues",   128'(issue_cnt_a), 128'd10);
    check("fips_r1_state", issue_log_a[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("fips_r2_state", issue_log_a[1], 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("idle_ready",    128'(ready_a), 128'd1);

    // Back-to-back with start held high
    d0 = done_cnt_a;
    @(negedge clk);
    pt_a    = FIPS_PT;
    start_a = 1'b1;
    wait_done_a(d0 + 1, 100, "b2b_first_timeout");
    d1_edge = done_edge_a;
    check("b2b_first_ct", done_ct_a, FIPS_CT);
    @(negedge clk);
    start_a = 1'b0;
    check("b2b_accept_edge", 128'(acc_edge_a - d1_edge), 128'd1);
    wait_done_a(d0 + 2, 100, "b2b_second_timeout");
    check("b2b_gap", 128'(done_edge_a - d1_edge), 128'd22);
    check("b2b_second_ct", done_ct_a, FIPS_CT);

    // Randomized keys and plaintexts against the reference
    for (int i = 0; i < 3; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(key);
      run_a(pt);
      check("rand_ct", ct_a, aes_ref(pt));
      check("rand_latency", 128'(done_edge_a - 1 - acc_edge_a), 128'd20);
    end
    load_key(FIPS_KEY);

    // Start pulse while busy is ignored
    d0 = done_cnt_a;
    @(negedge clk);
    pt_a = FIPS_PT;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (rk_idx_a != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_reach_r5", 128'(rk_idx_a), 128'd5);
    pt_a    = '1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    pt_a    = FIPS_PT;
    wait_done_a(d0 + 1, 100, "busy_done_timeout");
    check("busy_ct", ct_a, FIPS_CT);
    repeat (30) @(negedge clk);
    check("busy_one_done", 128'(done_cnt_a - d0), 128'd1);

    // Reset during round 6 wait
    d0 = done_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(rk_idx_a == 4'd6 && !dp_issue_a && !ready_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_r6_wait", 128'(rk_idx_a), 128'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",  128'(ready_a),    128'd1);
    check("mid_rst_done",   128'(done_a),     128'd0);
    check("mid_rst_ct",     ct_a,             128'd0);
    check("mid_rst_rk_idx", 128'(rk_idx_a),   128'd0);
    check("mid_rst_issue",  128'(dp_issue_a), 128'd0);
    repeat (30) @(negedge clk);
    check("mid_no_done", 128'(done_cnt_a - d0), 128'd0);
    check("mid_ct_held", ct_a, 128'd0);
    run_a(FIPS_PT);
    check("mid_fresh_ct", ct_a, FIPS_CT);
    check("mid_fresh_latency", 128'(done_edge_a - 1 - acc_edge_a), 128'd20);

    // Stub datapath instance, DP_LAT=3
    for (int i = 0; i < 3; i++) begin
      pt = (i == 0) ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      d0 = done_cnt_b;
      @(negedge clk);
      pt_b    = pt;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (done_cnt_b == d0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("stub_done_seen", 128'(done_cnt_b - d0), 128'd1);
      check("stub_ct", ct_b, stub_ref(pt));
      check("stub_latency", 128'(done_edge_b - 1 - acc_edge_b), 128'd40);
      check("stub_issues", 128'(issue_cnt_b), 128'd10);
      check("stub_bypass_cnt", 128'(bypass_cnt_b), 128'd1);
      check("stub_bypass_at", 128'(bypass_at_b), 128'd10);
    end
    check("stub_ct_zero_pt", stub_ref(128'd0), 128'h0b);
    check("stub_bypass_stray", 128'(bypass_stray_b), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
